// File: rtl/updown_pkg.sv
// Shared types and step arithmetic for the up/down counter FSM.
//   state_t    : press-detection FSM states
//   step_res_t : {wrap, next} result of one step
//   step_calc  : one up/down step with wrap or clamp at the range bounds
package updown_pkg;

  localparam int unsigned CALC_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HELD_UP = 3'd1,
    HELD_DN = 3'd2,
    RPT_UP  = 3'd3,
    RPT_DN  = 3'd4,
    BOTH    = 3'd5
  } state_t;

  typedef struct packed {
    logic              wrap;
    logic [CALC_W-1:0] next;
  } step_res_t;

  // One step of size step_v; one extra bit of headroom so v+step never overflows.
  function automatic step_res_t step_calc(
    input logic [CALC_W-1:0] v,
    input logic              up,
    input logic [CALC_W-1:0] min_v,
    input logic [CALC_W-1:0] max_v,
    input logic [CALC_W-1:0] step_v,
    input logic              sat
  );
    step_res_t         res;
    logic [CALC_W:0]   sum;
    logic [CALC_W:0]   lim;
    logic [CALC_W:0]   one;
    one      = (CALC_W+1)'(1);
    res.wrap = 1'b0;
    res.next = v;
    if (up) begin
      sum = {1'b0, v} + {1'b0, step_v};
      if (sum > {1'b0, max_v}) begin
        res.wrap = 1'b1;
        res.next = sat ? max_v
                       : CALC_W'({1'b0, min_v} + sum - {1'b0, max_v} - one);
      end else begin
        res.next = CALC_W'(sum);
      end
    end else begin
      // v-step < min  <=>  v < min+step, evaluated without going negative
      lim = {1'b0, min_v} + {1'b0, step_v};
      if ({1'b0, v} < lim) begin
        res.wrap = 1'b1;
        res.next = sat ? min_v
                       : CALC_W'({1'b0, max_v} - (lim - {1'b0, v} - one));
      end else begin
        res.next = v - step_v;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/updown_counter_fsm_step.sv
// Combinational next-value / wrap calculation for one counter step.
//   value_i  : current count
//   up_i     : 1 = step up, 0 = step down
//   next_c_o : count after the step
//   wrap_c_o : step wrapped (or clamped when saturating)
module updown_step
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = 255,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_c_o,
  output logic             wrap_c_o
);

  step_res_t res_c;

  always_comb begin
    res_c    = step_calc(CALC_W'(value_i), up_i, CALC_W'(MIN_VAL), CALC_W'(MAX_VAL),
                         CALC_W'(STEP), (SATURATE != 0));
    next_c_o = WIDTH'(res_c.next);
    wrap_c_o = res_c.wrap;
  end

endmodule

// File: rtl/updown_counter_fsm.sv
// Two-button up/down counter: one step per press, both-pressed lockout,
// optional auto-repeat while a single button is held.
//   clk, reset (async, active-low)
//   u, d    : debounced, synchronous up/down buttons (level)
//   clr     : synchronous clear of count to MIN_VAL
//   count   : registered count
//   at_max  : count == MAX_VAL (combinational)
//   at_min  : count == MIN_VAL (combinational)
//   wrap    : one-cycle pulse after a step that wrapped or clamped
module updown_counter_fsm
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned MAX_VAL       = 255,
  parameter int unsigned STEP          = 1,
  parameter int unsigned SATURATE      = 0,
  parameter int unsigned HOLD_CYCLES   = 0,
  parameter int unsigned REPEAT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             u,
  input  logic             d,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam int unsigned TMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW        = $clog2((TMAX > 2) ? TMAX : 2);
  localparam int unsigned HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int unsigned RPT_LAST  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic             step_c;
  logic             dir_up_c;
  logic             held_c;
  logic             other_c;
  logic [WIDTH-1:0] step_next_c;
  logic             step_wrap_c;

  // Direction of the step taken this edge; in IDLE a lone press decides it.
  assign dir_up_c = (state_q == IDLE) ? u : ((state_q == HELD_UP) || (state_q == RPT_UP));
  assign held_c   = dir_up_c ? u : d;
  assign other_c  = dir_up_c ? d : u;

  updown_step #(
    .WIDTH    (WIDTH),
    .MIN_VAL  (MIN_VAL),
    .MAX_VAL  (MAX_VAL),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_step (
    .value_i  (count_q),
    .up_i     (dir_up_c),
    .next_c_o (step_next_c),
    .wrap_c_o (step_wrap_c)
  );

  // State, timer and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= WIDTH'(MIN_VAL);
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Press detection, lockout and auto-repeat timing.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_c  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (u && !d) begin
          step_c  = 1'b1;
          state_d = HELD_UP;
        end else if (!u && d) begin
          step_c  = 1'b1;
          state_d = HELD_DN;
        end else if (u && d) begin
          state_d = BOTH;
        end
      end
      HELD_UP, HELD_DN: begin
        if (!held_c) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (other_c) begin
          state_d = BOTH;
          timer_d = '0;
        end else if (HOLD_CYCLES > 0) begin
          if (timer_q == TW'(HOLD_LAST)) begin
            step_c  = 1'b1;
            timer_d = '0;
            state_d = (state_q == HELD_UP) ? RPT_UP : RPT_DN;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      RPT_UP, RPT_DN: begin
        if (!held_c) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (other_c) begin
          state_d = BOTH;
          timer_d = '0;
        end else if (timer_q == TW'(RPT_LAST)) begin
          step_c  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      BOTH: begin
        timer_d = '0;
        if (!u && !d) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Count update; clear wins over any step but leaves the FSM running.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = WIDTH'(MIN_VAL);
    end else if (step_c) begin
      count_d = step_next_c;
      wrap_d  = step_wrap_c;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign at_max = (count_q == WIDTH'(MAX_VAL));
  assign at_min = (count_q == WIDTH'(MIN_VAL));

endmodule

// File: tb/tb_updown_counter_fsm.sv
// Four counter configurations side by side, each compared every cycle
// against a behavioural model through an expected-value queue.
//   0: defaults          1: 0..9 step 3 wrap
//   2: 2..9 step 3 clamp 3: 0..255 step 1, hold 4 / repeat 2
module tb_updown_counter_fsm;

  logic            clk;
  logic            reset;
  logic [3:0]      u_v, d_v, clr_v;
  logic [3:0][7:0] cnt_o;
  logic [3:0]      amax, amin, wrp;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int dut;
    int cnt;
    bit wrap;
  } exp_t;

  exp_t sb[$];

  int m_cnt [4];
  int m_mode[4];   // 0 idle, 1 up held, 2 down held, 3 both
  int m_age [4];
  bit m_wrap[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  updown_counter_fsm #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(255), .STEP(1), .SATURATE(0),
                       .HOLD_CYCLES(0), .REPEAT_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .u(u_v[0]), .d(d_v[0]), .clr(clr_v[0]),
    .count(cnt_o[0]), .at_max(amax[0]), .at_min(amin[0]), .wrap(wrp[0]));

  updown_counter_fsm #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .STEP(3), .SATURATE(0),
                       .HOLD_CYCLES(0), .REPEAT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .u(u_v[1]), .d(d_v[1]), .clr(clr_v[1]),
    .count(cnt_o[1]), .at_max(amax[1]), .at_min(amin[1]), .wrap(wrp[1]));

  updown_counter_fsm #(.WIDTH(8), .MIN_VAL(2), .MAX_VAL(9), .STEP(3), .SATURATE(1),
                       .HOLD_CYCLES(0), .REPEAT_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .u(u_v[2]), .d(d_v[2]), .clr(clr_v[2]),
    .count(cnt_o[2]), .at_max(amax[2]), .at_min(amin[2]), .wrap(wrp[2]));

  updown_counter_fsm #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(255), .STEP(1), .SATURATE(0),
                       .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut3 (
    .clk(clk), .reset(reset), .u(u_v[3]), .d(d_v[3]), .clr(clr_v[3]),
    .count(cnt_o[3]), .at_max(amax[3]), .at_min(amin[3]), .wrap(wrp[3]));

  function automatic int p_min(int i);  return (i == 2) ? 2 : 0;                endfunction
  function automatic int p_max(int i);  return (i == 1 || i == 2) ? 9 : 255;    endfunction
  function automatic int p_step(int i); return (i == 1 || i == 2) ? 3 : 1;      endfunction
  function automatic bit p_sat(int i);  return (i == 2);                        endfunction
  function automatic int p_hold(int i); return (i == 3) ? 4 : 0;                endfunction
  function automatic int p_rep(int i);  return (i == 3) ? 2 : 1;                endfunction

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Range-offset formulation of one step: offset from MIN, fold by range size.
  function automatic int calc(input int i, input int v, input bit up, output bit w);
    int rng;
    int off;
    rng = p_max(i) - p_min(i) + 1;
    off = up ? (v - p_min(i) + p_step(i)) : (v - p_min(i) - p_step(i));
    w = 1'b0;
    if (off >= rng) begin
      w = 1'b1;
      return p_sat(i) ? p_max(i) : p_min(i) + off - rng;
    end
    if (off < 0) begin
      w = 1'b1;
      return p_sat(i) ? p_min(i) : p_max(i) + 1 + off;
    end
    return p_min(i) + off;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = p_min(i);
      m_mode[i] = 0;
      m_age[i]  = 0;
      m_wrap[i] = 1'b0;
    end
  endfunction

  // Model one rising edge: m_age counts edges since the press was accepted.
  function automatic void model_edge(int i);
    bit st, up, w, held, oth;
    int nc;
    st = 1'b0; up = 1'b0; w = 1'b0;
    case (m_mode[i])
      0: begin
        if (u_v[i] && !d_v[i])      begin st = 1'b1; up = 1'b1; m_mode[i] = 1; m_age[i] = 0; end
        else if (!u_v[i] && d_v[i]) begin st = 1'b1; up = 1'b0; m_mode[i] = 2; m_age[i] = 0; end
        else if (u_v[i] && d_v[i])  m_mode[i] = 3;
      end
      1, 2: begin
        held = (m_mode[i] == 1) ? u_v[i] : d_v[i];
        oth  = (m_mode[i] == 1) ? d_v[i] : u_v[i];
        if (!held)    m_mode[i] = 0;
        else if (oth) m_mode[i] = 3;
        else begin
          m_age[i]++;
          if (p_hold(i) > 0 && m_age[i] >= p_hold(i) && ((m_age[i] - p_hold(i)) % p_rep(i)) == 0) begin
            st = 1'b1;
            up = (m_mode[i] == 1);
          end
        end
      end
      default: if (!u_v[i] && !d_v[i]) m_mode[i] = 0;
    endcase
    nc = m_cnt[i];
    if (st) nc = calc(i, m_cnt[i], up, w);
    if (clr_v[i]) begin
      nc = p_min(i);
      w  = 1'b0;
    end
    m_cnt[i]  = nc;
    m_wrap[i] = w;
  endfunction

  // One clock: predict all four, then compare after the edge.
  task automatic tick();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      model_edge(i);
      e.dut  = i;
      e.cnt  = m_cnt[i];
      e.wrap = m_wrap[i];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("d%0d count", e.dut), int'(cnt_o[e.dut]), e.cnt);
      check($sformatf("d%0d wrap", e.dut), int'(wrp[e.dut]), int'(e.wrap));
      check($sformatf("d%0d at_max", e.dut), int'(amax[e.dut]), int'(e.cnt == p_max(e.dut)));
      check($sformatf("d%0d at_min", e.dut), int'(amin[e.dut]), int'(e.cnt == p_min(e.dut)));
    end
  endtask

  task automatic press(input int i, input bit up);
    if (up) u_v[i] = 1'b1; else d_v[i] = 1'b1;
    tick();
    u_v[i] = 1'b0;
    d_v[i] = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    u_v = '0; d_v = '0; clr_v = '0;
    m_reset();
    #20;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst d%0d count", i), int'(cnt_o[i]), p_min(i));
      check($sformatf("rst d%0d wrap", i), int'(wrp[i]), 0);
      check($sformatf("rst d%0d at_min", i), int'(amin[i]), 1);
      check($sformatf("rst d%0d at_max", i), int'(amax[i]), 0);
    end
    #7 reset = 1'b1;

    // one step per press regardless of press length
    u_v[0] = 1'b1; repeat (10) tick();
    u_v[0] = 1'b0; tick();
    check("A long press", int'(cnt_o[0]), 1);
    u_v[0] = 1'b1; repeat (3) tick();
    u_v[0] = 1'b0; tick();
    check("A second press", int'(cnt_o[0]), 2);
    press(0, 1'b0);
    check("A down press", int'(cnt_o[0]), 1);

    // wrap mode, 0..9 step 3
    repeat (3) press(1, 1'b1);
    check("B at nine", int'(cnt_o[1]), 9);
    u_v[1] = 1'b1; tick();
    check("B wrap up count", int'(cnt_o[1]), 2);
    check("B wrap up pulse", int'(wrp[1]), 1);
    u_v[1] = 1'b0; tick();
    check("B pulse ends", int'(wrp[1]), 0);
    repeat (3) press(1, 1'b1);
    check("B at one", int'(cnt_o[1]), 1);
    d_v[1] = 1'b1; tick();
    check("B wrap dn count", int'(cnt_o[1]), 8);
    check("B wrap dn pulse", int'(wrp[1]), 1);
    d_v[1] = 1'b0; tick();

    // saturate mode, 2..9 step 3
    repeat (2) press(2, 1'b1);
    check("C at eight", int'(cnt_o[2]), 8);
    u_v[2] = 1'b1; tick();
    check("C clamp count", int'(cnt_o[2]), 9);
    check("C clamp pulse", int'(wrp[2]), 1);
    u_v[2] = 1'b0; tick();
    u_v[2] = 1'b1; tick();
    check("C at bound count", int'(cnt_o[2]), 9);
    check("C at bound pulse", int'(wrp[2]), 1);
    check("C at bound at_max", int'(amax[2]), 1);
    u_v[2] = 1'b0; tick();
    repeat (3) press(2, 1'b0);
    check("C clamp low", int'(cnt_o[2]), 2);

    // auto-repeat: steps at edges 0,4,6,8 of a 10-edge hold
    u_v[3] = 1'b1; repeat (10) tick();
    check("D repeat total", int'(cnt_o[3]), 4);
    u_v[3] = 1'b0; tick();

    // both-pressed lockout
    u_v[0] = 1'b1; d_v[0] = 1'b1; repeat (2) tick();
    check("E both", int'(cnt_o[0]), 1);
    d_v[0] = 1'b0; repeat (2) tick();
    check("E release d", int'(cnt_o[0]), 1);
    u_v[0] = 1'b0; tick();
    press(0, 1'b0);
    check("E down after both", int'(cnt_o[0]), 0);

    // async reset in the middle of a repeat
    u_v[3] = 1'b1; repeat (7) tick();
    check("F before reset", int'(cnt_o[3]), 7);
    #3 reset = 1'b0;
    m_reset();
    #2;
    check("F async count", int'(cnt_o[3]), 0);
    check("F async at_min", int'(amin[3]), 1);
    check("F async wrap", int'(wrp[1]), 0);
    #2 reset = 1'b1;
    tick();
    check("F held at deassert", int'(cnt_o[3]), 1);

    // clear coincident with a press, then no re-step while held
    u_v[3] = 1'b0; tick();
    u_v[3] = 1'b1; clr_v[3] = 1'b1; tick();
    check("G clr press count", int'(cnt_o[3]), 0);
    check("G clr press wrap", int'(wrp[3]), 0);
    clr_v[3] = 1'b0; repeat (2) tick();
    u_v[3] = 1'b0; tick();
    check("G after release", int'(cnt_o[3]), 0);
    u_v[1] = 1'b1; clr_v[1] = 1'b1; tick();
    check("G clr over wrap count", int'(cnt_o[1]), 0);
    check("G clr over wrap pulse", int'(wrp[1]), 0);
    clr_v[1] = 1'b0; tick();
    u_v[1] = 1'b0; tick();
    check("G held no restep", int'(cnt_o[1]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
